// File: rtl/xc_malu_seq.sv
// Sequencer for the multi-cycle MALU datapath: owns count/acc/arg registers,
// runs the CPU valid/ready/flush handshake and registers the final result.
module xc_malu_seq #(
   parameter int CW      = 6,
   parameter int TIMEOUT = 63
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          valid,
   input  logic          flush,
   input  logic          op_any,
   output logic [CW-1:0] count,
   output logic [63:0]   acc,
   output logic [31:0]   arg_0,
   output logic [31:0]   arg_1,
   output logic          dp_valid,
   input  logic [63:0]   n_acc,
   input  logic [31:0]   n_arg_0,
   input  logic [31:0]   n_arg_1,
   input  logic          dp_ready,
   input  logic [63:0]   dp_result,
   output logic [63:0]   result,
   output logic          err,
   output logic          ready
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   state_t      state, state_n;
   logic        clr, step, fin, fin_err;
   logic [63:0] fin_res;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_n;
   end

   // flush outranks every state transition, including completion in RUN
   always_comb begin
      state_n = state;
      clr     = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      fin_err = 1'b0;
      fin_res = '0;
      if (flush) begin
         state_n = IDLE;
         clr     = 1'b1;
      end else begin
         case (state)
            IDLE: if (valid) begin
               if (op_any) begin
                  state_n = RUN;
                  clr     = 1'b1;
               end else begin
                  state_n = DONE;
                  fin     = 1'b1;
                  fin_err = 1'b1;
               end
            end
            RUN: if (dp_ready) begin
               state_n = DONE;
               fin     = 1'b1;
               fin_res = dp_result;
            end else if (count == TMO) begin
               state_n = DONE;
               fin     = 1'b1;
               fin_err = 1'b1;
            end else begin
               step = 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // timeout test precedes the increment, so count never wraps
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
         acc   <= '0;
         arg_0 <= '0;
         arg_1 <= '0;
      end else if (clr) begin
         count <= '0;
         acc   <= '0;
         arg_0 <= '0;
         arg_1 <= '0;
      end else if (step) begin
         count <= count + CW'(1);
         acc   <= n_acc;
         arg_0 <= n_arg_0;
         arg_1 <= n_arg_1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         result <= '0;
         err    <= 1'b0;
         ready  <= 1'b0;
      end else begin
         ready <= (state_n == DONE);
         if (fin) begin
            result <= fin_res;
            err    <= fin_err;
         end
      end
   end

   assign dp_valid = (state == RUN);

endmodule

// File: doc/xc_malu_seq.md
Name: xc_malu_seq

Overview:
- Sequencer and state-holding stage directly upstream of the multi-cycle MALU datapath (mul/div/rem/pmul/clmul).
- Owns the count, acc, arg_0 and arg_1 registers, feeds them to the datapath, and latches the datapath's next-state values each cycle.
- Implements the valid/ready handshake with the CPU pipeline, including flush.
- Registers the final 64-bit result.

Parameters:
- CW, 6, count register width.
- TIMEOUT, 63, count value at which the operation is force-terminated with err=1.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- valid  in  1  CPU: operation request; held until ready
- flush  in  1  CPU: abandon current operation
- op_any  in  1  OR of all do_* op flags, decoded by the CPU
- count  out  CW  current count, to datapath
- acc  out  64  current accumulator, to datapath
- arg_0  out  32  current arg 0, to datapath
- arg_1  out  32  current arg 1, to datapath
- dp_valid  out  1  datapath operands/registers live (state RUN)
- n_acc  in  64  datapath next accumulator
- n_arg_0  in  32  datapath next arg 0
- n_arg_1  in  32  datapath next arg 1
- dp_ready  in  1  datapath finished; dp_result is final
- dp_result  in  64  datapath result
- result  out  64  registered result to CPU
- err  out  1  registered: operation timed out or no op selected
- ready  out  1  one-cycle completion pulse to CPU

Behaviour:
- Reset, asynchronous on resetn low:
  - state=IDLE.
  - count, acc, arg_0, arg_1, result, err all 0.
  - ready=0, dp_valid=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - valid && !flush && op_any: count, acc, arg_0 and arg_1 cleared to 0; go to RUN.
  - valid && !flush && !op_any: result=0, err=1; go to DONE.
- RUN (dp_valid=1):
  - At count==0 the datapath reads rs1/rs2/rs3 directly; zeroed registers are the defined start state.
  - dp_ready=1: result<=dp_result, err<=0; go to DONE. acc/arg_*/count are not updated.
  - Else, count==TIMEOUT: result<=0, err<=1; go to DONE.
  - Else: acc<=n_acc, arg_0<=n_arg_0, arg_1<=n_arg_1, count<=count+1; stay in RUN.
- DONE:
  - ready=1 for exactly this cycle; result and err are valid.
  - Next state is IDLE unconditionally.
  - result and err hold their value until the next completion or reset.
- ready is a registered decode of state==DONE, not combinational from dp_ready.
- Latency: operation accepted in cycle T, dp_ready asserted in RUN cycle T+1+k, ready=1 in cycle T+2+k. Minimum 3 cycles, valid to ready inclusive.
- The CPU must drop valid, or present a new op, in the cycle after ready. If valid is still high in IDLE, a new operation starts; this is intended back-to-back behaviour.
- flush, any state, has priority over everything:
  - Next state IDLE; count, acc, arg_0 and arg_1 cleared.
  - No ready pulse; result and err unchanged.
  - flush in DONE suppresses nothing already emitted, and the ready pulse of that cycle still occurs.
  - valid && flush in IDLE: no start.
- valid dropped mid-RUN without flush: the operation continues to completion. The CPU is expected to use flush to abandon.
- count never wraps, because the TIMEOUT check precedes the increment (requires TIMEOUT ≤ 2^CW−1).
- Reset asserted mid-operation returns to the reset values immediately; there is no ready pulse.

Test Plan:
- Reset, then idle: all outputs 0; dp_valid=0.
- valid=1, op_any=1; stub returns n_acc=acc+1 and asserts dp_ready at count==3 with dp_result=64'h2A:
  - acc sequence 0,1,2,3.
  - ready pulses exactly once, 5 cycles after accept.
  - result=64'h2A, err=0.
- Stub never asserts dp_ready: count reaches 63, then ready=1, err=1, result=0, count holds 63.
- flush asserted at count==2 during RUN:
  - Next cycle state IDLE, count=0, acc=0, no ready pulse.
  - result keeps the previous value 64'h2A.
- valid=1 with op_any=0: ready the next cycle; err=1, result=0.
- valid held high across completion:
  - A second operation starts in the IDLE cycle after DONE.
  - Both ready pulses are observed, each 1 cycle wide, with no overlap of register state.
